// File: rtl/trivium_decrypt.sv
// Trivium stream-cipher byte decryptor.
// Warm-up after key/IV load, then XORs 8 keystream bits per ciphertext byte.
module trivium_decrypt #(
    parameter int INIT_ROUNDS = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key,
    input  logic [79:0] iv,
    output logic        busy,
    input  logic        ct_valid,
    output logic        ct_ready,
    input  logic [7:0]  ct_data,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic [7:0]  pt_data
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] READY = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    localparam logic [10:0] LAST_INIT = 11'(INIT_ROUNDS - 1);
    localparam logic [10:0] LAST_BIT  = 11'd7;

    // r_s[i-1] holds cipher state bit s(i)
    logic [287:0] r_s;
    logic [2:0]   r_state;
    logic [10:0]  r_cnt;
    logic [7:0]   r_ct;
    logic [7:0]   r_pt;

    logic [287:0] w_load;
    logic [287:0] w_next;
    logic         w_t1;
    logic         w_t2;
    logic         w_t3;
    logic         w_n1;
    logic         w_n2;
    logic         w_n3;
    logic         w_z;

    assign w_load = {3'b111, 112'd0, iv, 13'd0, key};

    // One Trivium round: keystream bit and the advanced state
    always_comb begin
        w_t1   = r_s[65] ^ r_s[92];
        w_t2   = r_s[161] ^ r_s[176];
        w_t3   = r_s[242] ^ r_s[287];
        w_z    = w_t1 ^ w_t2 ^ w_t3;
        w_n1   = w_t1 ^ (r_s[90] & r_s[91]) ^ r_s[170];
        w_n2   = w_t2 ^ (r_s[174] & r_s[175]) ^ r_s[263];
        w_n3   = w_t3 ^ (r_s[285] & r_s[286]) ^ r_s[68];
        w_next = {r_s[286:177], w_n2,
                  r_s[175:93], w_n1,
                  r_s[91:0], w_n3};
    end

    // Control FSM, state advance only in INIT and SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_ct    <= '0;
            r_pt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_s     <= w_load;
                        r_cnt   <= '0;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_s <= w_next;
                    if (r_cnt == LAST_INIT) begin
                        r_cnt   <= '0;
                        r_state <= READY;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                READY: begin
                    if (start) begin
                        r_s     <= w_load;
                        r_cnt   <= '0;
                        r_state <= INIT;
                    end else if (ct_valid) begin
                        r_ct    <= ct_data;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_s  <= w_next;
                    r_ct <= {1'b0, r_ct[7:1]};
                    r_pt <= {r_ct[0] ^ w_z, r_pt[7:1]};
                    if (r_cnt == LAST_BIT) begin
                        r_cnt   <= '0;
                        r_state <= OUT;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                OUT: begin
                    if (pt_ready) begin
                        r_state <= READY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // start wins over a byte offered in the same READY cycle
    assign busy     = (r_state == INIT);
    assign ct_ready = (r_state == READY) && !start;
    assign pt_valid = (r_state == OUT);
    assign pt_data  = r_pt;

endmodule

// File: tb/tb_trivium_decrypt.sv
// Testbench for trivium_decrypt.
// Random traffic against a bit-array Trivium reference model.
module tb_trivium_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic [79:0] iv;
    logic        busy;
    logic        ct_valid;
    logic        ct_ready;
    logic [7:0]  ct_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [7:0]  pt_data;

    logic        b_start;
    logic        b_busy;
    logic        b_ctv;
    logic        b_ctr;
    logic [7:0]  b_ctd;
    logic        b_ptv;
    logic        b_ptr;
    logic [7:0]  b_ptd;

    int n_chk = 0;
    int n_err = 0;

    bit ms[1:288];

    logic [7:0] ref_ct[64];
    logic [7:0] ref_pt[64];

    always #5 clk = ~clk;

    trivium_decrypt dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .iv       (iv),
        .busy     (busy),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data)
    );

    trivium_decrypt #(.INIT_ROUNDS(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .key      (80'd0),
        .iv       (80'd0),
        .busy     (b_busy),
        .ct_valid (b_ctv),
        .ct_ready (b_ctr),
        .ct_data  (b_ctd),
        .pt_valid (b_ptv),
        .pt_ready (b_ptr),
        .pt_data  (b_ptd)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: state bits numbered 1..288 as in the cipher definition
    task automatic m_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endtask

    task automatic m_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic m_byte(input logic [7:0] ct, output logic [7:0] pt);
        bit z;
        for (int k = 0; k < 8; k++) begin
            m_round(z);
            pt[k] = ct[k] ^ z;
        end
    endtask

    task automatic rand80(output logic [79:0] v);
        v[31:0]  = $urandom;
        v[63:32] = $urandom;
        v[79:64] = 16'($urandom);
    endtask

    task automatic start_main(input logic [79:0] k, input logic [79:0] v,
                              input bit with_ct);
        int n;
        bit z;
        key      = k;
        iv       = v;
        start    = 1'b1;
        ct_valid = with_ct;
        ct_data  = 8'($urandom);
        #1;
        chk("ct_ready_vs_start", 32'(ct_ready), 0);
        tick();
        start    = 1'b0;
        ct_valid = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("busy_len", n, 1152);
        m_load(k, v);
        repeat (1152) m_round(z);
    endtask

    task automatic xfer(input logic [7:0] ct, input int gap_ct,
                        input int gap_pt, input bit start_mid,
                        output logic [7:0] pt);
        int n;
        bit ok;
        logic [7:0] exp;
        repeat (gap_ct) tick();
        ct_valid = 1'b1;
        ct_data  = ct;
        n = 0;
        while (!ct_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ct_ready", 32'(ct_ready), 1);
        tick();
        ct_valid = 1'b0;
        ct_data  = 8'($urandom);
        n = 0;
        while (!pt_valid && n < 50) begin
            if (start_mid && n == 3) begin
                rand80(key);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        chk("latency", n, 8);
        m_byte(ct, exp);
        pt = pt_data;
        chk("pt_data", 32'(pt_data), 32'(exp));
        ok = 1'b1;
        repeat (gap_pt) begin
            tick();
            if (!pt_valid || pt_data !== exp || ct_ready || busy) ok = 1'b0;
        end
        if (gap_pt > 0) chk("hold_stable", 32'(ok), 1);
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        chk("pt_drop", 32'(pt_valid), 0);
    endtask

    task automatic b_run(input logic [7:0] ct, output logic [7:0] pt,
                         output int lat);
        int n;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (!b_ctr && n < 20) begin
            tick();
            n++;
        end
        b_ctv = 1'b1;
        b_ctd = ct;
        tick();
        b_ctv = 1'b0;
        lat = 0;
        while (!b_ptv && lat < 50) begin
            tick();
            lat++;
        end
        pt    = b_ptd;
        b_ptr = 1'b1;
        tick();
        b_ptr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ctr"}, 32'(ct_ready), 0);
        chk({tag, "_ptv"}, 32'(pt_valid), 0);
        chk({tag, "_ptd"}, 32'(pt_data), 0);
    endtask

    initial begin
        logic [79:0] k0;
        logic [79:0] v0;
        logic [7:0]  p;
        int          lat;
        int          n;
        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        iv       = '0;
        ct_valid = 1'b0;
        ct_data  = '0;
        pt_ready = 1'b0;
        b_start  = 1'b0;
        b_ctv    = 1'b0;
        b_ctd    = '0;
        b_ptr    = 1'b0;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        b_run(8'h00, p, lat);
        chk("b_pt00", 32'(p), 32'h03);
        chk("b_lat00", lat, 8);
        b_run(8'hFF, p, lat);
        chk("b_ptFF", 32'(p), 32'hFC);
        chk("b_latFF", lat, 8);

        rand80(k0);
        rand80(v0);
        start_main(k0, v0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            ref_ct[i] = 8'($urandom);
            xfer(ref_ct[i], int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'b0, ref_pt[i]);
        end

        xfer(8'($urandom), 0, 20, 1'b0, p);
        xfer(8'($urandom), 1, 0, 1'b0, p);

        xfer(8'($urandom), 0, 0, 1'b1, p);
        xfer(8'($urandom), 0, 0, 1'b0, p);

        rand80(k0);
        start_main(k0, v0, 1'b1);
        xfer(8'($urandom), 0, 1, 1'b0, p);

        key   = k0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("mid_init_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_init");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_ctr", 32'(ct_ready), 0);

        start_main(k0, v0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ref_ct[i] = 8'($urandom);
            xfer(ref_ct[i], int'($urandom_range(0, 2)), 0, 1'b0, ref_pt[i]);
        end

        start_main(k0, v0, 1'b0);
        ct_valid = 1'b1;
        ct_data  = ref_ct[0];
        tick();
        ct_valid = 1'b0;
        n = 0;
        while (!pt_valid && n < 50) begin
            tick();
            n++;
        end
        chk("out_reached", 32'(pt_valid), 1);
        chk("replay0", 32'(pt_data), 32'(ref_pt[0]));
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_out");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_ptv", 32'(pt_valid), 0);

        start_main(k0, v0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            xfer(ref_ct[i], int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'b0, p);
            chk("replay", 32'(p), 32'(ref_pt[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
